// File: rtl/item_pkg.sv
// item_pkg -- shared definitions for the item decoder.
//   N_ITEMS / N_CAT : item and category line counts
//   IDX_W           : width of the scan index
//   CATn_MASK       : one-hot item membership of each category
//   state_e         : decoder FSM states
//   is_onehot_cat   : true when a category select has exactly one bit set
//   popcount_items  : number of set bits in an item mask
// Used by item_cat_rom and item_decoder. Optional macro ITEM_DEC_COUNT_EN
// (in item_decoder) uses popcount_items.
package item_pkg;

  localparam int N_ITEMS = 40;
  localparam int N_CAT   = 5;
  localparam int IDX_W   = 6;

  // Bit i set means item i belongs to the category. The five masks are
  // disjoint and together cover all 40 items, matching the item encoder.
  localparam logic [N_ITEMS-1:0] CAT0_MASK = 40'h86_4091_9048;
  localparam logic [N_ITEMS-1:0] CAT1_MASK = 40'h40_0000_0206;
  localparam logic [N_ITEMS-1:0] CAT2_MASK = 40'h09_0800_0501;
  localparam logic [N_ITEMS-1:0] CAT3_MASK = 40'h20_060C_2030;
  localparam logic [N_ITEMS-1:0] CAT4_MASK = 40'h10_B162_4880;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  function automatic logic is_onehot_cat(input logic [N_CAT-1:0] v);
    return (v != '0) && ((v & (v - 5'd1)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] popcount_items(input logic [N_ITEMS-1:0] m);
    logic [IDX_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      cnt = cnt + {{(IDX_W-1){1'b0}}, m[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/item_cat_rom.sv
// item_cat_rom -- combinational category-to-item-mask lookup.
//   cat_sel [N_CAT-1:0]   in  : one-hot category
//   mask    [N_ITEMS-1:0] out : member mask of that category; all-zero for
//                               a select that is not one-hot
module item_cat_rom
  import item_pkg::*;
(
  input  logic [N_CAT-1:0]   cat_sel,
  output logic [N_ITEMS-1:0] mask
);

  always_comb begin
    mask = '0;
    case (cat_sel)
      5'b00001: mask = CAT0_MASK;
      5'b00010: mask = CAT1_MASK;
      5'b00100: mask = CAT2_MASK;
      5'b01000: mask = CAT3_MASK;
      5'b10000: mask = CAT4_MASK;
      default:  mask = '0;
    endcase
  end

endmodule

// File: rtl/item_decoder.sv
// item_decoder -- enumerates the items of a selected category, one index
// per cycle, as a stream of one-hot item lines.
//   clk, rst            : clock, synchronous active-high reset
//   cat_sel   [4:0]  in : one-hot category, sampled when a request is taken
//   req_valid        in : request present
//   req_ready        out: high exactly while idle
//   req_err          out: one-cycle pulse after a malformed cat_sel is taken
//   item_no   [39:0] out: one-hot item on offer, zero when item_valid=0
//   item_valid       out: item_no is a member of the selected category
//   item_ready       in : consumer takes item_no this cycle
//   item_last        out: offered item is the highest member of the category
//   item_count [5:0] out: member count of the active category (only with
//                         macro ITEM_DEC_COUNT_EN defined)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; while item_valid=1 and item_ready=0 the offered item is held.
module item_decoder #(
  parameter int N_ITEMS = item_pkg::N_ITEMS,
  parameter int N_CAT   = item_pkg::N_CAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CAT-1:0]   cat_sel,
  input  logic               req_valid,
  output logic               req_ready,
  output logic               req_err,
  output logic [N_ITEMS-1:0] item_no,
  output logic               item_valid,
  input  logic               item_ready,
  output logic               item_last
`ifdef ITEM_DEC_COUNT_EN
  ,
  output logic [5:0]         item_count
`endif
);

  import item_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITEMS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_ITEMS-1:0] mask_q, mask_d;
  logic               err_q, err_d;

  logic [N_ITEMS-1:0] rom_mask;
  logic [N_ITEMS-1:0] mask_above;
  logic               accept_ok;
  logic               scan_done;

  item_cat_rom u_rom (
    .cat_sel (cat_sel),
    .mask    (rom_mask)
  );

  // Output decode depends only on registered state, so the offered item
  // cannot glitch with item_ready.
  always_comb begin
    mask_above = mask_q >> idx_q;
    req_ready  = (state_q == ST_IDLE);
    req_err    = err_q;
    item_valid = (state_q == ST_SCAN) && mask_q[idx_q];
    // Last member: nothing set strictly above the current index.
    item_last  = item_valid && ((mask_above >> 1) == '0);
    item_no    = item_valid ? ({{(N_ITEMS-1){1'b0}}, 1'b1} << idx_q) : '0;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    err_d     = 1'b0;
    accept_ok = 1'b0;
    scan_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_onehot_cat(cat_sel)) begin
            accept_ok = 1'b1;
            mask_d    = rom_mask;
            idx_d     = '0;
            state_d   = ST_SCAN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        // Advance over non-members freely; members only when taken.
        if (!item_valid || item_ready) begin
          // The index bound is a backstop; every category has a last
          // member, so exit normally happens through item_last.
          if ((item_valid && item_last) || (idx_q == LAST_IDX)) begin
            scan_done = 1'b1;
            state_d   = ST_IDLE;
            idx_d     = '0;
            mask_d    = '0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        mask_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

`ifdef ITEM_DEC_COUNT_EN
  logic [5:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (accept_ok) begin
      count_d = popcount_items(rom_mask);
    end else if (scan_done) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign item_count = count_q;
`endif

endmodule

// File: tb/tb_item_decoder.sv
// tb_item_decoder -- directed bench for item_decoder. Define
// ITEM_DEC_COUNT_EN for both bench and design to cover item_count.
module tb_item_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  cat_sel;
  logic        req_valid;
  logic        req_ready;
  logic        req_err;
  logic [39:0] item_no;
  logic        item_valid;
  logic        item_ready;
  logic        item_last;
`ifdef ITEM_DEC_COUNT_EN
  logic [5:0]  item_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Item-to-category encoder table, item index -> category.
  int item_cat [40] = '{2, 1, 1, 0, 3, 3, 0, 4, 2, 1,
                        2, 4, 0, 3, 4, 0, 0, 4, 3, 3,
                        0, 4, 4, 0, 4, 3, 3, 2, 4, 4,
                        0, 4, 2, 0, 0, 2, 4, 3, 1, 0};

  int          emit_cyc [40];
  int          first_emit;
  int          first_hold;
  int          end_cyc;
  int          tot_emit;
  logic [39:0] seen_all;

  item_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .cat_sel    (cat_sel),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_err    (req_err),
    .item_no    (item_no),
    .item_valid (item_valid),
    .item_ready (item_ready),
    .item_last  (item_last)
`ifdef ITEM_DEC_COUNT_EN
    ,
    .item_count (item_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int last_member(input int cat);
    for (int i = 39; i >= 0; i--) if (item_cat[i] == cat) return i;
    return -1;
  endfunction

  function automatic int n_members(input int cat);
    int n = 0;
    for (int i = 0; i < 40; i++) if (item_cat[i] == cat) n++;
    return n;
  endfunction

  // Re-encodes a one-hot item line; 7 flags a line that is not one-hot.
  function automatic int encode_item(input logic [39:0] v);
    int n = 0;
    int c = 7;
    for (int i = 0; i < 40; i++) if (v[i]) begin n++; c = item_cat[i]; end
    return (n == 1) ? c : 7;
  endfunction

  function automatic logic [63:0] out_vec();
    return {21'd0, req_ready, item_valid, item_last, item_no};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_idle"}, out_vec(), {21'd0, 1'b1, 1'b0, 1'b0, 40'd0});
    check({tag, "_err"}, {63'd0, req_err}, 64'd0);
`ifdef ITEM_DEC_COUNT_EN
    check({tag, "_cnt"}, {58'd0, item_count}, 64'd0);
`endif
  endtask

  // Runs one category scan. mode 0: item_ready=1; mode 1: random ready;
  // mode 2: hold ready low for the first 5 cycles the first member is offered.
  // Cycle c is the cycle following the c-th edge after the accept edge.
  task automatic run_scan(input int cat, input int mode);
    int          c;
    int          m_idx;
    int          stall;
    int          last_i;
    bit          done;
    bit          rdy;
    logic        exp_valid, exp_last;
    logic [39:0] exp_no;
    last_i     = last_member(cat);
    first_emit = -1;
    first_hold = 0;
    for (int i = 0; i < 40; i++) emit_cyc[i] = 0;
    cat_sel   = 5'(1 << cat);
    req_valid = 1'b1;
    step();
    c     = 1;
    m_idx = 0;
    stall = 0;
    done  = 1'b0;
    while (!done && c < 300) begin
      exp_valid = (item_cat[m_idx] == cat);
      exp_last  = exp_valid && (m_idx == last_i);
      exp_no    = exp_valid ? (40'd1 << m_idx) : 40'd0;
      check($sformatf("scan_c%0d_cyc%0d", cat, c), out_vec(),
            {21'd0, 1'b0, exp_valid, exp_last, exp_no});
`ifdef ITEM_DEC_COUNT_EN
      check($sformatf("count_c%0d_cyc%0d", cat, c), {58'd0, item_count},
            64'(n_members(cat)));
`endif
      if (item_valid)
        check($sformatf("reenc_c%0d_cyc%0d", cat, c), 64'(encode_item(item_no)), 64'(cat));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(exp_valid && first_emit < 0 && stall < 5);
      endcase
      if (exp_valid && !rdy) stall++;
      if (item_valid && first_emit < 0 && item_no == exp_no) first_hold++;
      item_ready = rdy;
      if (item_valid && rdy) begin
        tot_emit++;
        seen_all = seen_all | item_no;
      end
      if (exp_valid && rdy) begin
        emit_cyc[m_idx] = c;
        if (first_emit < 0) first_emit = m_idx;
        if (exp_last) done = 1'b1;
      end
      if (!exp_valid || rdy) m_idx++;
      // Requests while scanning must be ignored; drop them before the exit edge.
      req_valid = done ? 1'b0 : 1'($urandom_range(0, 1));
      cat_sel   = 5'($urandom_range(0, 31));
      step();
      c++;
    end
    if (!done) check($sformatf("scan_c%0d_timeout", cat), 64'd0, 64'd1);
    end_cyc    = c;
    item_ready = 1'b0;
    check_idle($sformatf("after_c%0d", cat));
  endtask

  task automatic bad_request(input logic [4:0] sel);
    cat_sel   = sel;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check($sformatf("err_pulse_%b", sel), {61'd0, req_err, req_ready, item_valid}, 64'b110);
    step();
    check($sformatf("err_clear_%b", sel), {61'd0, req_err, req_ready, item_valid}, 64'b010);
    step();
    check($sformatf("err_quiet_%b", sel), {61'd0, req_err, req_ready, item_valid}, 64'b010);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          guard;
    rst        = 1'b1;
    cat_sel    = 5'd0;
    req_valid  = 1'b0;
    item_ready = 1'b0;
    tot_emit   = 0;
    seen_all   = '0;
    step();
    step();
    check_idle("in_reset");
    rst = 1'b0;
    step();
    check_idle("post_reset");

    // cat1 with item_ready held high: exact offer cycles.
    run_scan(1, 0);
    check("cat1_cyc_item1",  64'(emit_cyc[1]),  64'd2);
    check("cat1_cyc_item2",  64'(emit_cyc[2]),  64'd3);
    check("cat1_cyc_item9",  64'(emit_cyc[9]),  64'd10);
    check("cat1_cyc_item38", 64'(emit_cyc[38]), 64'd39);
    check("cat1_ready_cyc",  64'(end_cyc),      64'd40);

    // cat2 with the first item (0) stalled for 5 cycles.
    run_scan(2, 2);
    check("cat2_first_item", 64'(first_emit), 64'd0);
    check("cat2_first_hold", 64'(first_hold), 64'd6);
    check("cat2_cyc_item8",  64'(emit_cyc[8]), 64'd14);

    // Malformed selects.
    bad_request(5'b00000);
    bad_request(5'b10001);

    // Reset while cat4 item 14 is on offer.
    cat_sel    = 5'b10000;
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
    item_ready = 1'b1;
    guard = 0;
    while (!(item_valid && item_no[14]) && guard < 40) begin
      step();
      guard++;
    end
    check("rst_reach_item14", {63'd0, item_no[14]}, 64'd1);
    rst        = 1'b1;
    item_ready = 1'b1;
    step();
    check_idle("abort_rst");
    rst        = 1'b0;
    item_ready = 1'b0;
    step();
    check_idle("abort_rel");
    run_scan(0, 0);
    check("cat0_first_item", 64'(first_emit), 64'd3);

    // Full sweep with random item_ready.
    tot_emit = 0;
    seen_all = '0;
    for (int k = 0; k < 5; k++) run_scan(k, 1);
    check("sweep_total", 64'(tot_emit), 64'd40);
    check("sweep_cover", {24'd0, seen_all}, {24'd0, 40'hFF_FFFF_FFFF});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so a stuck design still produces a summary line.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule
